// File: rtl/dmac_ctrl_pkg.sv
// rtl/dmac_ctrl_pkg.sv - DMAC register map, STATUS bits and command FSM states
package dmac_ctrl_pkg;

    localparam logic [2:0] REG_SRC    = 3'd0;
    localparam logic [2:0] REG_DST    = 3'd1;
    localparam logic [2:0] REG_LEN    = 3'd2;
    localparam logic [2:0] REG_CTRL   = 3'd4;
    localparam logic [2:0] REG_STATUS = 3'd5;

    localparam int ST_DONE = 0;
    localparam int ST_BUSY = 1;

    typedef enum logic [3:0] {
        IDLE,
        WR_SRC,
        WR_DST,
        WR_LEN,
        WR_GO,
        GAP,
        POLL,
        CLR,
        FIN,
        ABORT
    } cmd_state_t;

endpackage

// File: rtl/dmac_cmd_master_if.sv
// rtl/dmac_cmd_master_if.sv - job port, job status and DMAC slave bus of the command master
interface dmac_cmd_master_if #(
    parameter int DATA_W = 32
);
    logic              iCmdValid;
    logic              oCmdReady;
    logic [DATA_W-1:0] iCmdSrc;
    logic [DATA_W-1:0] iCmdDst;
    logic [DATA_W-1:0] iCmdLen;
    logic              oDone;
    logic              oError;
    logic              oBusy;
    logic              oChipselect;
    logic              oRead;
    logic              oWrite;
    logic [2:0]        oAddress;
    logic [DATA_W-1:0] oWritedata;
    logic [DATA_W-1:0] iReaddata;

    modport master (
        input  iCmdValid, iCmdSrc, iCmdDst, iCmdLen, iReaddata,
        output oCmdReady, oDone, oError, oBusy,
        output oChipselect, oRead, oWrite, oAddress, oWritedata
    );

    modport slave (
        output iCmdValid, iCmdSrc, iCmdDst, iCmdLen, iReaddata,
        input  oCmdReady, oDone, oError, oBusy,
        input  oChipselect, oRead, oWrite, oAddress, oWritedata
    );
endinterface

// File: rtl/dmac_poll_timer.sv
// rtl/dmac_poll_timer.sv - STATUS poll gap down-counter and saturating poll counter
module dmac_poll_timer #(
    parameter int POLL_GAP = 16,
    parameter int TIMEOUT  = 65536
) (
    input  logic iClk,
    input  logic iReset,
    input  logic start,
    input  logic reload,
    input  logic tick,
    output logic gap_expired,
    output logic timeout_hit
);
    localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [GAP_W-1:0] gap_q, gap_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The gap counter is reloaded on every GAP entry, so letting it run down
    // outside GAP is harmless.
    always_comb begin
        gap_d = gap_q;
        if (reload) begin
            gap_d = GAP_W'(POLL_GAP - 1);
        end else if (gap_q != '0) begin
            gap_d = gap_q - 1'b1;
        end

        cnt_d = cnt_q;
        if (start) begin
            cnt_d = '0;
        end else if (tick && (cnt_q != CNT_W'(TIMEOUT))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            gap_q <= '0;
            cnt_q <= '0;
        end else begin
            gap_q <= gap_d;
            cnt_q <= cnt_d;
        end
    end

    // timeout_hit counts the read in progress, so it fires on the TIMEOUT-th poll.
    assign gap_expired = (gap_q == '0);
    assign timeout_hit = (cnt_q >= CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/dmac_cmd_master.sv
// rtl/dmac_cmd_master.sv - programs the DMAC slave per job, polls STATUS until DONE or timeout
module dmac_cmd_master
    import dmac_ctrl_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int POLL_GAP = 16,
    parameter int TIMEOUT  = 65536
) (
    input  logic                  iClk,
    input  logic                  iReset,
    dmac_cmd_master_if.master     bus
);
    cmd_state_t        state_q, state_d;
    logic [DATA_W-1:0] src_q, src_d, dst_q, dst_d, len_q, len_d;
    logic              accept;
    logic              gap_expired, timeout_hit;

    logic              cmd_ready_q, done_q, error_q, error_d, busy_q;
    logic              read_q, read_d, write_q, write_d;
    logic [2:0]        addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              unused_readdata;
    assign unused_readdata = ^bus.iReaddata[DATA_W-1:1];

    assign accept = (state_q == IDLE) && bus.iCmdValid;

    always_comb begin
        src_d   = accept ? bus.iCmdSrc : src_q;
        dst_d   = accept ? bus.iCmdDst : dst_q;
        len_d   = accept ? bus.iCmdLen : len_q;
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = (bus.iCmdLen == '0) ? FIN : WR_SRC;
            WR_SRC:  state_d = WR_DST;
            WR_DST:  state_d = WR_LEN;
            WR_LEN:  state_d = WR_GO;
            WR_GO:   state_d = GAP;
            GAP:     if (gap_expired) state_d = POLL;
            POLL: begin
                if (bus.iReaddata[ST_DONE]) state_d = CLR;
                else if (timeout_hit)       state_d = ABORT;
                else                        state_d = GAP;
            end
            CLR:     state_d = FIN;
            FIN:     state_d = IDLE;
            ABORT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus outputs are decoded from the next state and registered, so each
    // access lands exactly in the cycle its state is occupied.
    always_comb begin
        read_d  = 1'b0;
        write_d = 1'b0;
        addr_d  = '0;
        wdata_d = '0;
        case (state_d)
            WR_SRC: begin write_d = 1'b1; addr_d = REG_SRC;    wdata_d = src_d;         end
            WR_DST: begin write_d = 1'b1; addr_d = REG_DST;    wdata_d = dst_d;         end
            WR_LEN: begin write_d = 1'b1; addr_d = REG_LEN;    wdata_d = len_d;         end
            WR_GO:  begin write_d = 1'b1; addr_d = REG_CTRL;   wdata_d = DATA_W'(1);    end
            POLL:   begin read_d  = 1'b1; addr_d = REG_STATUS;                          end
            CLR:    begin write_d = 1'b1; addr_d = REG_STATUS; wdata_d = DATA_W'(1);    end
            ABORT:  begin write_d = 1'b1; addr_d = REG_CTRL;   wdata_d = '0;            end
            default: ;
        endcase

        error_d = error_q;
        if (accept)            error_d = 1'b0;
        if (state_d == ABORT)  error_d = 1'b1;
    end

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            state_q     <= IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            len_q       <= '0;
            cmd_ready_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            busy_q      <= 1'b0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            len_q       <= len_d;
            cmd_ready_q <= (state_d == IDLE);
            done_q      <= (state_d == FIN);
            error_q     <= error_d;
            busy_q      <= !(state_d inside {IDLE, FIN, ABORT});
            read_q      <= read_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
        end
    end

    dmac_poll_timer #(
        .POLL_GAP (POLL_GAP),
        .TIMEOUT  (TIMEOUT)
    ) u_timer (
        .iClk        (iClk),
        .iReset      (iReset),
        .start       (accept),
        .reload      ((state_d == GAP) && (state_q != GAP)),
        .tick        (state_q == POLL),
        .gap_expired (gap_expired),
        .timeout_hit (timeout_hit)
    );

    assign bus.oCmdReady   = cmd_ready_q;
    assign bus.oDone       = done_q;
    assign bus.oError      = error_q;
    assign bus.oBusy       = busy_q;
    assign bus.oRead       = read_q;
    assign bus.oWrite      = write_q;
    assign bus.oChipselect = read_q | write_q;
    assign bus.oAddress    = addr_q;
    assign bus.oWritedata  = wdata_q;

endmodule
